// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan: captures three BCD digits and drives a 3-digit, common-anode,
// time-multiplexed 7-segment display with a dark guard interval at the
// start of each digit slot, optional leading-zero blanking, a dash for
// invalid codes and a one-cycle frame strobe.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   load      in   capture strobe for hund/tens/ones/blank_lz
//   hund      in   [3:0] BCD hundreds digit
//   tens      in   [3:0] BCD tens digit
//   ones      in   [3:0] BCD ones digit
//   blank_lz  in   1 = blank leading zeros (sampled with load)
//   an        out  [2:0] active-low anodes: [0]=ones, [1]=tens, [2]=hund
//   seg       out  [6:0] active-low segments {g,f,e,d,c,b,a}
//   frame     out  one-cycle pulse when the slot index wraps from 2 to 0
module bcd_seg_scan #(
    parameter int unsigned REFRESH_DIV = 1000,
    parameter int unsigned GUARD       = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] hund,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    input  logic       blank_lz,
    output logic [2:0] an,
    output logic [6:0] seg,
    output logic       frame
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);
    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'h3F;

    logic [CNT_W-1:0] count_q, count_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       hund_q, hund_d;
    logic [3:0]       tens_q, tens_d;
    logic [3:0]       ones_q, ones_d;
    logic             blz_q, blz_d;
    logic [2:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             frame_q, frame_d;

    logic             wrap_c;
    logic             dark_c;
    logic [3:0]       digit_c;
    logic             blank_c;

    // BCD to active-low {g..a}; codes above 9 show a dash
    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    // Divider, slot rotator, capture and registered pin logic
    always_comb begin
        count_d = count_q;
        idx_d   = idx_q;
        hund_d  = hund_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        blz_d   = blz_q;
        an_d    = 3'b111;
        seg_d   = SEG_OFF;
        frame_d = 1'b0;
        digit_c = ones_q;
        blank_c = 1'b0;

        wrap_c = (count_q == CNT_LAST);
        // GUARD=0 disables the dark interval entirely
        dark_c = (GUARD != 0) && (count_q < CNT_GUARD);

        if (wrap_c) begin
            count_d = '0;
            idx_d   = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
            frame_d = (idx_q == 2'd2);
        end else begin
            count_d = count_q + CNT_W'(1);
        end

        if (load) begin
            hund_d = hund;
            tens_d = tens;
            ones_d = ones;
            blz_d  = blank_lz;
        end

        // Slot digit select; only literal zeros count for blanking
        case (idx_q)
            2'd1: begin
                digit_c = tens_q;
                blank_c = blz_q && (hund_q == 4'd0) && (tens_q == 4'd0);
            end
            2'd2: begin
                digit_c = hund_q;
                blank_c = blz_q && (hund_q == 4'd0);
            end
            default: begin
                digit_c = ones_q;
                blank_c = 1'b0;
            end
        endcase

        if (!dark_c) begin
            an_d  = ~(3'b001 << idx_q);
            seg_d = blank_c ? SEG_OFF : decode(digit_c);
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            idx_q   <= 2'd0;
            hund_q  <= 4'd0;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
            blz_q   <= 1'b0;
            an_q    <= 3'b111;
            seg_q   <= SEG_OFF;
            frame_q <= 1'b0;
        end else begin
            count_q <= count_d;
            idx_q   <= idx_d;
            hund_q  <= hund_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            blz_q   <= blz_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            frame_q <= frame_d;
        end
    end

    assign an    = an_q;
    assign seg   = seg_q;
    assign frame = frame_q;

endmodule
